// File: rtl/debounce_scan_scheduler_pkg.sv
// Shared defaults, slot-action encoding and timing helpers for the debounce scan scheduler.
`timescale 1ns/100ps
package debounce_pkg;

   localparam int unsigned N_CH_DEF     = 4;
   localparam int unsigned CNT_W_DEF    = 2;
   localparam int unsigned SCAN_DIV_DEF = 1;

   function automatic int unsigned cnt_max(input int unsigned cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

   localparam int unsigned CNT_MAX = cnt_max(CNT_W_DEF);

   typedef enum logic [1:0] {
      ACT_HOLD,
      ACT_CLEAR,
      ACT_INC,
      ACT_COMMIT
   } slot_action_t;

   // Worst-case cycles from a clean input step to the committed level change.
   function automatic int unsigned latency_bound(input int unsigned n_ch,
                                                 input int unsigned cnt_w,
                                                 input int unsigned scan_div);
      return 2 + n_ch * scan_div * ((1 << cnt_w) + 1);
   endfunction

endpackage

// File: rtl/debounce_scan_scheduler_sync_2ff.sv
// Two-flop synchroniser for one raw button input.
`timescale 1ns/100ps
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/debounce_scan_scheduler.sv
// Round-robin debounce engine: one shared stability counter datapath visits each
// synchronised channel once per scan slot and commits after 2^CNT_W mismatching visits.
`timescale 1ns/100ps
module debounce_scan_scheduler
   import debounce_pkg::*;
#(
   parameter int unsigned N_CH     = N_CH_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned SCAN_DIV = SCAN_DIV_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         in_signal,
   output logic [N_CH-1:0]         out_signal,
   output logic [N_CH-1:0]         out_signal_enable,
   output logic [$clog2(N_CH)-1:0] scan_ch
);

   localparam int unsigned PTR_W = $clog2(N_CH);
   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(cnt_max(CNT_W));
   localparam logic [DIV_W-1:0] SLOT_TOP = DIV_W'(SCAN_DIV - 1);
   localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(N_CH - 1);

   logic [N_CH-1:0]  sync_level;
   logic [DIV_W-1:0] slot_cnt;
   logic             slot_tick;
   logic [CNT_W-1:0] cnt [N_CH];

   logic             sel_sync;
   logic             sel_out;
   logic [CNT_W-1:0] sel_cnt;
   slot_action_t     action;

   for (genvar g = 0; g < N_CH; g++) begin : g_sync
      sync_2ff u_sync (
         .clk (clk),
         .rst (rst),
         .d   (in_signal[g]),
         .q   (sync_level[g])
      );
   end

   assign slot_tick = (slot_cnt == SLOT_TOP);
   assign sel_sync  = sync_level[scan_ch];
   assign sel_out   = out_signal[scan_ch];
   assign sel_cnt   = cnt[scan_ch];

   always_comb begin
      action = ACT_HOLD;
      if (slot_tick) begin
         if (sel_sync == sel_out) begin
            action = ACT_CLEAR;
         end else if (sel_cnt == CNT_TOP) begin
            action = ACT_COMMIT;
         end else begin
            action = ACT_INC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt          <= '0;
         scan_ch           <= '0;
         out_signal        <= '0;
         out_signal_enable <= '0;
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         out_signal_enable <= '0;
         slot_cnt          <= slot_tick ? '0 : slot_cnt + DIV_W'(1);
         if (slot_tick) begin
            scan_ch <= (scan_ch == PTR_TOP) ? '0 : scan_ch + PTR_W'(1);
         end
         // Only the visited channel's counter moves; all others hold implicitly.
         case (action)
            ACT_CLEAR: cnt[scan_ch] <= '0;
            ACT_INC:   cnt[scan_ch] <= sel_cnt + CNT_W'(1);
            ACT_COMMIT: begin
               cnt[scan_ch]               <= '0;
               out_signal[scan_ch]        <= sel_sync;
               out_signal_enable[scan_ch] <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// Bench for debounce_scan_scheduler: default build plus an N_CH=2/SCAN_DIV=3 build,
// both checked every cycle against a visit-count model, with directed and random stimulus.
`timescale 1ns/100ps
module tb_debounce_scan_scheduler;
   import debounce_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_signal;
   logic [3:0] out_signal;
   logic [3:0] out_en;
   logic [1:0] scan;
   logic [1:0] in2;
   logic [1:0] out2;
   logic [1:0] en2;
   logic [0:0] scan2;

   always #10 clk = ~clk;

   debounce_scan_scheduler dut (
      .clk               (clk),
      .rst               (rst),
      .in_signal         (in_signal),
      .out_signal        (out_signal),
      .out_signal_enable (out_en),
      .scan_ch           (scan)
   );

   debounce_scan_scheduler #(.N_CH(2), .CNT_W(2), .SCAN_DIV(3)) dut2 (
      .clk               (clk),
      .rst               (rst),
      .in_signal         (in2),
      .out_signal        (out2),
      .out_signal_enable (en2),
      .scan_ch           (scan2)
   );

   // Model: channel p is visited when cycle index k (since reset) ends a slot;
   // a commit happens on the fourth consecutive visit that sees sync != out.
   int unsigned cfg_n   [2] = '{4, 2};
   int unsigned cfg_div [2] = '{1, 3};
   int unsigned k       [2];
   int unsigned miss    [2][4];
   logic [3:0]  m_out   [2];
   logic [3:0]  m_en    [2];
   logic [3:0]  m_s1    [2];
   logic [3:0]  m_s2    [2];

   task automatic model_step(input int c, input logic r, input logic [3:0] din);
      int unsigned p;
      if (r) begin
         m_out[c] = '0;
         m_en[c]  = '0;
         m_s1[c]  = '0;
         m_s2[c]  = '0;
         k[c]     = 0;
         for (int i = 0; i < 4; i++) miss[c][i] = 0;
      end else begin
         p = (k[c] / cfg_div[c]) % cfg_n[c];
         m_en[c] = '0;
         if ((k[c] % cfg_div[c]) == cfg_div[c] - 1) begin
            if (m_s2[c][p] != m_out[c][p]) begin
               miss[c][p]++;
               if (miss[c][p] == 4) begin
                  m_out[c][p] = m_s2[c][p];
                  m_en[c][p]  = 1'b1;
                  miss[c][p]  = 0;
               end
            end else begin
               miss[c][p] = 0;
            end
         end
         k[c]++;
         m_s2[c] = m_s1[c];
         m_s1[c] = din;
      end
   endtask

   always @(posedge clk) begin
      model_step(0, rst, in_signal);
      model_step(1, rst, {2'b00, in2});
   end

   function automatic int m_ptr(input int c);
      return int'((k[c] / cfg_div[c]) % cfg_n[c]);
   endfunction

   int checks = 0;
   int errors = 0;
   int strb  [4];
   int strb2 [2];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
      end
   endtask

   task automatic compare_all();
      chk("out_signal", int'(out_signal), int'(m_out[0]));
      chk("out_enable", int'(out_en), int'(m_en[0]));
      chk("scan_ch", int'(scan), m_ptr(0));
      chk("enable_onehot", int'($countones(out_en) <= 1), 1);
      chk("out_signal2", int'(out2), int'(m_out[1][1:0]));
      chk("out_enable2", int'(en2), int'(m_en[1][1:0]));
      chk("scan_ch2", int'(scan2), m_ptr(1));
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
      for (int i = 0; i < 4; i++) if (out_en[i]) strb[i]++;
      for (int i = 0; i < 2; i++) if (en2[i]) strb2[i]++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      int cnt;
      int snap;
      int snaps [4];
      logic [3:0] mask;
      logic       prev;
      int idx;

      for (int i = 0; i < 4; i++) strb[i] = 0;
      for (int i = 0; i < 2; i++) strb2[i] = 0;

      // Reset with all inputs held high
      rst = 1'b1;
      in_signal = 4'hF;
      in2 = 2'b11;
      repeat (3) begin
         step();
         chk("rst_out", int'(out_signal), 0);
         chk("rst_en", int'(out_en), 0);
         chk("rst_scan", int'(scan), 0);
      end
      rst = 1'b0;
      cnt = 0;
      mask = '0;
      repeat (30) begin
         step();
         if (out_en != 0) begin
            cnt++;
            mask |= out_en;
         end
      end
      chk("release_strobe_count", cnt, 4);
      chk("release_strobe_mask", int'(mask), 15);
      chk("release_out", int'(out_signal), 15);

      // Clean press on channel 2
      in_signal = 4'h0;
      do_reset();
      repeat (10) step();
      snap = strb[2];
      in_signal[2] = 1'b1;
      n = 0;
      while (!out_signal[2] && n < 40) begin
         step();
         n++;
         if (out_en[2]) chk("press_strobe_pattern", int'(out_en), 4);
      end
      chk_range("press_latency", n, 15, int'(latency_bound(4, 2, 1)));
      repeat (10) step();
      chk("press_strobes", strb[2] - snap, 1);
      chk("press_out", int'(out_signal), 4);

      // Bounce on channel 1, then settle high
      snap = strb[1];
      fork
         begin
            #0.5;
            for (int i = 0; i < 20; i++) begin
               in_signal[1] = 1'($urandom_range(1));
               #3;
            end
            in_signal[1] = 1'b1;
         end
         begin
            repeat (3) step();
         end
      join
      chk("bounce_no_strobe", strb[1] - snap, 0);
      n = 0;
      while (!out_signal[1] && n < 40) begin
         step();
         n++;
      end
      repeat (10) step();
      chk("bounce_strobes", strb[1] - snap, 1);
      chk("bounce_out", int'(out_signal[1]), 1);

      // Eight-cycle glitch on channel 0
      snap = strb[0];
      in_signal[0] = 1'b1;
      repeat (8) step();
      in_signal[0] = 1'b0;
      repeat (40) step();
      chk("glitch_strobes", strb[0] - snap, 0);
      chk("glitch_out", int'(out_signal[0]), 0);

      // All channels rise together
      in_signal = 4'h0;
      do_reset();
      repeat (8) step();
      for (int i = 0; i < 4; i++) snaps[i] = strb[i];
      in_signal = 4'hF;
      n = 0;
      while (out_signal != 4'hF && n < 40) begin
         step();
         n++;
      end
      chk_range("simul_latency", n, 15, 22);
      repeat (5) step();
      for (int i = 0; i < 4; i++) chk("simul_strobes", strb[i] - snaps[i], 1);

      // Slow-scan build: pointer cadence and a 1->0 release
      repeat (10) step();
      chk("div3_held_out", int'(out2), 3);
      prev = scan2[0];
      n = 0;
      while (scan2[0] == prev && n < 10) begin
         step();
         n++;
      end
      prev = scan2[0];
      n = 0;
      while (scan2[0] == prev && n < 10) begin
         step();
         n++;
      end
      chk("div3_scan_period", n, 3);
      snap = strb2[0];
      in2[0] = 1'b0;
      n = 0;
      while (out2[0] && n < 50) begin
         step();
         n++;
      end
      chk_range("div3_release_latency", n, 1, int'(latency_bound(2, 2, 3)));
      repeat (5) step();
      chk("div3_release_strobes", strb2[0] - snap, 1);

      // Random activity with occasional reset pulses
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(7) == 0) begin
            idx = int'($urandom_range(3));
            in_signal[idx] = ~in_signal[idx];
         end
         if ($urandom_range(15) == 0) begin
            idx = int'($urandom_range(1));
            in2[idx] = ~in2[idx];
         end
         rst = ($urandom_range(299) == 0);
         step();
      end
      rst = 1'b0;
      repeat (5) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
